// File: rtl/wb_slave_regfile.sv
// Wishbone B3 classic-cycle register file responder.
// ID word at index 0, byte-lane writes, programmable wait states, error on miss.
module wb_slave_regfile #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE    = 32'hD5B0_0001
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [15:0] access_count_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  hit_q;
    logic                  we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           dat_q;
    logic [31:0]           mask_q;
    logic [31:0]           mem [DEPTH];

    logic                  req;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           sel_mask;
    logic                  commit;
    logic                  unused;

    assign req    = wb_cyc_i & wb_stb_i;
    assign hit    = wb_adr_i[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2];
    assign idx    = wb_adr_i[DEPTH_LOG2+1:2];
    assign unused = ^wb_adr_i[1:0];

    assign sel_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                       {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    // A write lands only when the transfer actually terminates with ack,
    // so an abort or a reset before RESP never touches the array.
    assign commit = (state == RESP) & hit_q & we_q & (idx_q != '0);

    // Bus FSM: request capture, wait-state countdown, registered termination.
    // New requests are ignored while ack/err is still visible so a master
    // holding stb through the terminating edge is not served twice.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state          <= IDLE;
            wait_cnt       <= 4'd0;
            hit_q          <= 1'b0;
            we_q           <= 1'b0;
            idx_q          <= '0;
            dat_q          <= 32'd0;
            mask_q         <= 32'd0;
            wb_ack_o       <= 1'b0;
            wb_err_o       <= 1'b0;
            wb_dat_o       <= 32'd0;
            access_count_o <= 16'd0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'd0;
            unique case (state)
                IDLE: begin
                    if (req && !wb_ack_o && !wb_err_o) begin
                        hit_q  <= hit;
                        we_q   <= wb_we_i;
                        idx_q  <= idx;
                        dat_q  <= wb_dat_i;
                        mask_q <= sel_mask;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (!hit_q) begin
                        wb_err_o <= 1'b1;
                    end else begin
                        wb_ack_o       <= 1'b1;
                        access_count_o <= access_count_o + 16'd1;
                        if (!we_q) begin
                            wb_dat_o <= (idx_q == '0) ? ID_VALUE : mem[idx_q];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register array; word 0 is never written and reads come from ID_VALUE.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (commit) begin
            mem[idx_q] <= (mem[idx_q] & ~mask_q) | (dat_q & mask_q);
        end
    end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Scoreboard bench for wb_slave_regfile: driver pushes expectations,
// a negedge monitor pops and compares on every ack/err.
module tb_wb_slave_regfile;

    localparam int unsigned WS       = 3;
    localparam logic [31:0] ID_VALUE = 32'hD5B0_0001;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic [15:0] count;

    wb_slave_regfile #(
        .DEPTH_LOG2 (4),
        .WAIT_STATES(WS),
        .BASE_ADDR  (32'h0000_0000),
        .ID_VALUE   (ID_VALUE)
    ) dut (
        .wb_clk        (clk),
        .wb_rst        (rst),
        .wb_adr_i      (adr),
        .wb_dat_i      (dat_w),
        .wb_sel_i      (sel),
        .wb_we_i       (we),
        .wb_cyc_i      (cyc),
        .wb_stb_i      (stb),
        .wb_dat_o      (dat_r),
        .wb_ack_o      (ack),
        .wb_err_o      (err),
        .access_count_o(count)
    );

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model[16];
    logic [15:0] mcnt;
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every termination must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (ack || err)) begin
            if (ack && err) begin
                checks++;
                errors++;
                $display("FAIL ack_err_both: ack=%b err=%b", ack, err);
            end
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_term: ack=%b err=%b dat=%h",
                         ack, err, dat_r);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("term_is_err", {31'd0, err}, {31'd0, e.is_err});
                chk("term_ack", {31'd0, ack}, {31'd0, ~e.is_err});
                chk("rd_data", dat_r, e.data);
                chk("acc_count", {16'd0, count}, {16'd0, e.cnt});
            end
        end
    end

    function automatic exp_t predict(input logic w, input logic [31:0] a,
                                     input logic [31:0] d,
                                     input logic [3:0] s);
        exp_t        e;
        logic [3:0]  word;
        word = a[5:2];
        if (a[31:6] != 26'd0) begin
            e = '{is_err: 1'b1, data: 32'd0, cnt: mcnt};
        end else begin
            mcnt = mcnt + 16'd1;
            if (w) begin
                if (word != 4'd0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) model[word][8*b +: 8] = d[8*b +: 8];
                    end
                end
                e = '{is_err: 1'b0, data: 32'd0, cnt: mcnt};
            end else begin
                e = '{is_err: 1'b0,
                      data: (word == 4'd0) ? ID_VALUE : model[word],
                      cnt: mcnt};
            end
        end
        return e;
    endfunction

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int n;
        sbq.push_back(predict(w, a, d, s));
        we    = w;
        adr   = a;
        dat_w = d;
        sel   = s;
        cyc   = 1'b1;
        stb   = 1'b1;
        @(posedge clk);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (ack || err) break;
            if (n >= 50) break;
        end
        chk("latency", n, WS + 2);
        @(posedge clk);
        #1;
        cyc   = 1'b0;
        stb   = 1'b0;
        adr   = $urandom;
        dat_w = $urandom;
    endtask

    task automatic aborted(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int j);
        we    = w;
        adr   = a;
        dat_w = d;
        sel   = 4'hF;
        cyc   = 1'b1;
        stb   = 1'b1;
        @(posedge clk);
        repeat (j) @(posedge clk);
        #1;
        if (j[0]) stb = 1'b0;
        else cyc = 1'b0;
        repeat (WS + 3) @(posedge clk);
        #1;
        cyc = 1'b0;
        stb = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic        w;
        checks = 0;
        errors = 0;
        mcnt   = 16'd0;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        rst   = 1'b1;
        adr   = 32'd0;
        dat_w = 32'd0;
        sel   = 4'd0;
        we    = 1'b0;
        cyc   = 1'b0;
        stb   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat", dat_r, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        xfer(1'b0, 32'h0, 32'h0, 4'hF);
        xfer(1'b1, 32'h4, 32'hCAFE_F00D, 4'hF);
        xfer(1'b0, 32'h4, 32'h0, 4'h0);
        xfer(1'b1, 32'h4, 32'h1122_3344, 4'b0101);
        xfer(1'b0, 32'h4, 32'h0, 4'hF);
        chk("byte_merge_model", model[1], 32'hCA22_F044);
        xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF);
        xfer(1'b0, 32'h0, 32'h0, 4'hF);
        xfer(1'b0, 32'h40, 32'h0, 4'hF);
        xfer(1'b1, 32'h40, 32'h1234_5678, 4'hF);
        xfer(1'b0, 32'h4, 32'h0, 4'hF);

        xfer(1'b1, 32'h8, 32'h0BAD_0BAD, 4'hF);
        for (int j = 0; j < WS; j++) begin
            aborted(1'b1, 32'h8, 32'hDEAD_BEEF ^ j, j);
        end
        xfer(1'b0, 32'h8, 32'h0, 4'hF);

        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
                if (a[31:6] == 26'd0) a[6] = 1'b1;
            end else begin
                a = {26'd0, 4'($urandom), 2'($urandom)};
            end
            if ($urandom_range(0, 15) == 0) begin
                aborted(w, a, $urandom, int'($urandom_range(0, WS - 1)));
            end else begin
                xfer(w, a, $urandom, 4'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        force dut.access_count_o = 16'hFFFF;
        #1;
        release dut.access_count_o;
        mcnt = 16'hFFFF;
        xfer(1'b0, 32'hC, 32'h0, 4'hF);
        xfer(1'b0, 32'h0, 32'h0, 4'hF);

        xfer(1'b1, 32'h4, 32'h5A5A_A5A5, 4'hF);
        we    = 1'b1;
        adr   = 32'h4;
        dat_w = 32'h5555_5555;
        sel   = 4'hF;
        cyc   = 1'b1;
        stb   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_dat", dat_r, 32'd0);
        chk("midrst_count", {16'd0, count}, 32'd0);
        cyc = 1'b0;
        stb = 1'b0;
        sbq.delete();
        mcnt = 16'd0;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        xfer(1'b0, 32'h4, 32'h0, 4'hF);
        repeat (4) @(posedge clk);

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: %0d expected terminations missing",
                     sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
